// File: rtl/clockworks_gearbox.sv
// -----------------------------------------------------------------------------
// clockworks_gearbox
//   Clock gearbox and reset generator between the board pins and the SOC core.
//   The board clock CLK is divided by 2^SLOW to give the core clock clk. A
//   clean, stretched core reset resetn is derived from the board reset RESET.
//   All flops run on CLK. clk is a divider counter bit, or CLK itself when
//   SLOW == 0.
//
// Parameters
//   SLOW        log2 of the divide ratio (0 = CLK passed straight through)
//   RST_CYCLES  clk rising edges resetn stays low after reset release (>= 1)
//
// Ports
//   CLK     in   board clock, the only clock in the block
//   RESET   in   board reset, asynchronous, active-low
//   clk     out  divided core clock, CLK / 2^SLOW, 50% duty cycle
//   resetn  out  core reset, active-low; asserts asynchronously and releases
//                on the CLK edge that produces a clk rising edge
// -----------------------------------------------------------------------------
module clockworks_gearbox #(
  parameter int SLOW       = 21,
  parameter int RST_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  localparam int CW = (SLOW >= 1) ? SLOW : 1;
  localparam int SW = $clog2(RST_CYCLES + 1);

  localparam logic [SW-1:0] STRETCH_MAX  = SW'(RST_CYCLES);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(RST_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          rise_ev;
  logic [1:0]    sync;
  logic          rst_ok;
  logic [SW-1:0] stretch;

  assign cnt_next = cnt + CW'(1);
  assign rst_ok   = sync[1];

  // clk and the "clk is about to rise" strobe. With SLOW == 0 every CLK edge
  // is a clk rising edge, so the stretch counter advances once per CLK.
  generate
    if (SLOW == 0) begin : g_pass
      assign clk     = CLK;
      assign rise_ev = 1'b1;
    end else begin : g_div
      assign clk     = cnt[SLOW-1];
      assign rise_ev = cnt_next[SLOW-1] & ~cnt[SLOW-1];
    end
  endgenerate

  // Divider counter; wraps naturally at 2^SLOW, so duty cycle is unaffected.
  // NOTE: RESET is used as an asynchronous clear on every flop so resetn
  // (and clk) drop immediately, even for a pulse shorter than one CLK cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values, regardless of statement order.
      cnt <= cnt_next;
    end
  end

  // Two-flop synchronizer for the release edge of RESET. A release that
  // coincides with a CLK edge may be taken one cycle later, never glitched.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  // Reset stretch: count clk rising edges once the release is synchronized;
  // resetn is raised on the same CLK edge that produces the final counted
  // clk rising edge, so it is never seen mid-period in the clk domain.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stretch <= '0;
      resetn  <= 1'b0;
    end else if (rst_ok && rise_ev && (stretch != STRETCH_MAX)) begin
      stretch <= stretch + SW'(1);
      if (stretch == STRETCH_LAST) begin
        resetn <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clockworks_gearbox.sv
// -----------------------------------------------------------------------------
// tb_clockworks_gearbox
//   Bench for clockworks_gearbox. Three instances (SLOW = 0, 2, 3) share the
//   board clock and reset. A reference model counts CLK edges since reset
//   release and clk rising edges seen after the synchronizer settles, and
//   derives the expected clk level and resetn from those counts.
// -----------------------------------------------------------------------------
module tb_clockworks_gearbox;

  localparam int RSTC = 4;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic [2:0] clk_s;
  logic [2:0] resetn_s;

  int tests  = 0;
  int failed = 0;

  int slows   [3] = '{0, 2, 3};
  int n_edges [3] = '{0, 0, 0};
  int n_rises [3] = '{0, 0, 0};

  always #5 CLK = ~CLK;

  clockworks_gearbox #(.SLOW(0), .RST_CYCLES(RSTC)) u_s0 (
    .CLK(CLK), .RESET(RESET), .clk(clk_s[0]), .resetn(resetn_s[0]));
  clockworks_gearbox #(.SLOW(2), .RST_CYCLES(RSTC)) u_s2 (
    .CLK(CLK), .RESET(RESET), .clk(clk_s[1]), .resetn(resetn_s[1]));
  clockworks_gearbox #(.SLOW(3), .RST_CYCLES(RSTC)) u_s3 (
    .CLK(CLK), .RESET(RESET), .clk(clk_s[2]), .resetn(resetn_s[2]));

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // clk rises on edge n when the counter value after that edge is P/2.
  function automatic bit is_rise(input int slow, input int n);
    if (slow == 0) return 1'b1;
    return (n % (1 << slow)) == (1 << (slow - 1));
  endfunction

  function automatic logic model_clk(input int slow, input int n, input logic phase);
    if (slow == 0) return phase;
    return logic'((n % (1 << slow)) >= (1 << (slow - 1)));
  endfunction

  // Reference model: edges since release; rises only count from the third
  // edge on, when the two-stage synchronizer has passed the release through.
  always @(posedge CLK or negedge RESET) begin
    for (int i = 0; i < 3; i++) begin
      if (!RESET) begin
        n_edges[i] = 0;
        n_rises[i] = 0;
      end else begin
        n_edges[i] = n_edges[i] + 1;
        if (n_edges[i] >= 3 && is_rise(slows[i], n_edges[i]))
          n_rises[i] = n_rises[i] + 1;
      end
    end
  end

  task automatic compare(input logic phase);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("clk_s%0d_ph%0d", slows[i], phase), clk_s[i],
            model_clk(slows[i], n_edges[i], phase));
      check($sformatf("resetn_s%0d", slows[i]), resetn_s[i],
            logic'(n_rises[i] >= RSTC));
    end
  endtask

  // Continuous comparison: low phase at the falling edge, high phase 1 ns
  // after the rising edge.
  initial begin
    forever begin
      @(negedge CLK);
      compare(1'b0);
      @(posedge CLK);
      #1 compare(1'b1);
    end
  end

  task automatic release_reset();
    @(negedge CLK);
    #2 RESET = 1'b1;
  endtask

  // After a release, resetn of the SLOW=2 instance must rise on edge 18.
  task automatic check_s2_release(input string tag);
    repeat (17) @(posedge CLK);
    #1 check({tag, "_s2_edge17"}, resetn_s[1], 1'b0);
    @(posedge CLK);
    #1 check({tag, "_s2_edge18"}, resetn_s[1], 1'b1);
  endtask

  initial begin
    int guard;

    // 1: held in reset
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    check("rst_clk_s2", clk_s[1], 1'b0);
    check("rst_clk_s3", clk_s[2], 1'b0);
    check("rst_resetn_s2", resetn_s[1], 1'b0);

    // 2/4/5: release, literal release edges (s0: 6, s2: 18, s3: 28)
    release_reset();
    repeat (5) @(posedge CLK);
    #1 check("s0_edge5", resetn_s[0], 1'b0);
    @(posedge CLK);
    #1 check("s0_edge6", resetn_s[0], 1'b1);
    repeat (11) @(posedge CLK);
    #1 check("s2_edge17", resetn_s[1], 1'b0);
    @(posedge CLK);
    #1 check("s2_edge18", resetn_s[1], 1'b1);
    check("s2_clk_edge18", clk_s[1], 1'b1);
    repeat (9) @(posedge CLK);
    #1 check("s3_edge27", resetn_s[2], 1'b0);
    @(posedge CLK);
    #1 check("s3_edge28", resetn_s[2], 1'b1);
    check("s3_clk_edge28", clk_s[2], 1'b1);
    repeat (20) @(negedge CLK);

    // 3: one-cycle pulse while resetn is high
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check("pulse_resetn_s2", resetn_s[1], 1'b0);
    check("pulse_clk_s2", clk_s[1], 1'b0);
    check("pulse_clk_s3", clk_s[2], 1'b0);
    release_reset();
    check_s2_release("pulse");

    // 6: drop during stretch when two rises have been counted
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    release_reset();
    guard = 0;
    while (n_rises[1] != 2 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("stretch2_reached", logic'(guard < 200), 1'b1);
    check("stretch2_resetn", resetn_s[1], 1'b0);
    #2 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    release_reset();
    check_s2_release("midstretch");

    // Sub-cycle pulse
    repeat (10) @(negedge CLK);
    #1 RESET = 1'b0;
    #1 check("short_resetn_s0", resetn_s[0], 1'b0);
    check("short_resetn_s3", resetn_s[2], 1'b0);
    #1 RESET = 1'b1;
    check_s2_release("short");

    // Randomized reset activity, including long runs across counter wraps
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(5, 70)) @(negedge CLK);
      @(negedge CLK);
      #($urandom_range(1, 3)) RESET = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        #1 RESET = 1'b1;
      end else begin
        repeat ($urandom_range(1, 4)) @(negedge CLK);
        #($urandom_range(1, 3)) RESET = 1'b1;
      end
    end
    repeat (120) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
